// File: rtl/timer_sched_pkg.sv
// Shared definitions for the two-requester delay-timer scheduler.
package timer_sched_pkg;

    // Default counter / delay width; terminal count is all-ones.
    localparam int W_DEF = 4;

    // Controller states, binary encoded in 2 bits.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // One-hot select for a two-entry requester index.
    function automatic logic [1:0] onehot2(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/timer_sched_cnt_sync_ld.sv
// W-bit synchronous up-counter with synchronous load (priority over enable),
// asynchronous active-low clear and an all-ones carry-out.
module cnt_sync_ld
    import timer_sched_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         CLK,
    input  logic         MR,
    input  logic         LD,
    input  logic         EN,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q,
    output logic         CO
);

    logic [W-1:0] q_reg;

    // Counter register: clear, else load, else count when enabled.
    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) begin
            q_reg <= '0;
        end else if (LD) begin
            q_reg <= D;
        end else if (EN) begin
            q_reg <= q_reg + 1'b1;
        end
    end

    assign Q  = q_reg;
    assign CO = &q_reg;

endmodule

// File: rtl/timer_sched.sv
// Round-robin arbiter and controller sharing one loadable counter as a
// programmable delay timer between two requesters.
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         CLK,
    input  logic         MR,
    input  logic         TICK,
    input  logic [1:0]   REQ,
    input  logic [W-1:0] DLY0,
    input  logic [W-1:0] DLY1,
    output logic [1:0]   GNT,
    output logic [1:0]   DONE,
    output logic         BUSY,
    output logic [W-1:0] CNT
);

    state_t       state_reg, state_next;
    logic         owner_reg, owner_next;
    logic [W-1:0] dly_reg,   dly_next;
    logic         ptr_reg,   ptr_next;

    logic         cnt_ld;
    logic         cnt_en;
    logic         cnt_co;
    logic         win;

    // Controller registers; everything returns to IDLE with requester 0 preferred.
    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) begin
            state_reg <= ST_IDLE;
            owner_reg <= 1'b0;
            dly_reg   <= '0;
            ptr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            dly_reg   <= dly_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Next-state logic: arbitration in IDLE, abort on owner drop, carry-out exit.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        dly_next   = dly_reg;
        ptr_next   = ptr_reg;
        cnt_ld     = 1'b0;
        cnt_en     = 1'b0;
        win        = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (REQ != 2'b00) begin
                    // A single request wins outright; a tie goes to the pointer.
                    win        = (REQ == 2'b11) ? ptr_reg : REQ[1];
                    owner_next = win;
                    dly_next   = win ? DLY1 : DLY0;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!REQ[owner_reg]) begin
                    // Abort before the load: the counter keeps its old value.
                    state_next = ST_IDLE;
                    ptr_next   = ~owner_reg;
                end else begin
                    cnt_ld     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!REQ[owner_reg]) begin
                    state_next = ST_IDLE;
                    ptr_next   = ~owner_reg;
                end else if (cnt_co) begin
                    // Leaving on carry-out keeps the counter from ever wrapping.
                    state_next = ST_FIN;
                end else begin
                    cnt_en = TICK;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
                ptr_next   = ~owner_reg;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Preloading the complement makes the delay end exactly at all-ones.
    cnt_sync_ld #(
        .W (W)
    ) u_cnt (
        .CLK (CLK),
        .MR  (MR),
        .LD  (cnt_ld),
        .EN  (cnt_en),
        .D   (~dly_reg),
        .Q   (CNT),
        .CO  (cnt_co)
    );

    assign BUSY = (state_reg != ST_IDLE);

    // Per-requester grant and completion outputs decoded from the owner.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign GNT[gi]  = BUSY && (owner_reg == 1'(gi));
            assign DONE[gi] = (state_reg == ST_FIN) && (owner_reg == 1'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_timer_sched.sv
// Randomized scoreboard bench for timer_sched: the stimulus side predicts
// grant / done / release events from a timeline model and queues them; a
// monitor compares them against what the DUT presents.
module tb_timer_sched;

    localparam int W = 4;
    localparam int TOP = 15;

    localparam int EV_GRANT = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_REL   = 2;

    logic         CLK  = 1'b0;
    logic         MR   = 1'b0;
    logic         TICK = 1'b0;
    logic [1:0]   REQ  = 2'b00;
    logic [W-1:0] DLY0 = '0;
    logic [W-1:0] DLY1 = '0;
    logic [1:0]   GNT;
    logic [1:0]   DONE;
    logic         BUSY;
    logic [W-1:0] CNT;

    typedef struct {
        int kind;
        int owner;
        int cyc;
        int cnt;
    } ev_t;

    ev_t q[$];
    int  cyc       = 0;
    int  n_checks  = 0;
    int  n_pass    = 0;
    int  ptr       = 0;
    int  cnt_model = 0;
    int  mr_count  = 0;

    timer_sched #(.W(W)) dut (
        .CLK  (CLK),
        .MR   (MR),
        .TICK (TICK),
        .REQ  (REQ),
        .DLY0 (DLY0),
        .DLY1 (DLY1),
        .GNT  (GNT),
        .DONE (DONE),
        .BUSY (BUSY),
        .CNT  (CNT)
    );

    initial forever #5 CLK = ~CLK;

    // Edge counter: during the cycle that follows edge k, cyc == k.
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, act, exp, cyc);
    endtask

    function automatic void push(input int kind, input int owner, input int c, input int cnt);
        ev_t e;
        e.kind = kind; e.owner = owner; e.cyc = c; e.cnt = cnt;
        q.push_back(e);
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        REQ = 2'b00;
        repeat (n) step();
    endtask

    // Pulse MR between clock edges; outputs must clear without a clock.
    task automatic do_mr();
        #1 MR = 1'b0;
        #1;
        check("mr_gnt", int'(GNT), 0);
        check("mr_done", int'(DONE), 0);
        check("mr_busy", int'(BUSY), 0);
        check("mr_cnt", int'(CNT), 0);
        REQ = 2'b00;
        q.delete();
        mr_count++;
        ptr = 0;
        cnt_model = 0;
        $display("reset pulse at cyc %0d", cyc);
        #1 MR = 1'b1;
    endtask

    // Compare one DUT-presented event against the head of the scoreboard.
    task automatic take_event(input int kind, input int owner, input int cnt);
        ev_t e;
        n_checks++;
        if (q.size() == 0) begin
            $display("FAIL event_unexpected: got kind=%0d owner=%0d cyc=%0d cnt=%0d, want none",
                     kind, owner, cyc, cnt);
        end else begin
            e = q.pop_front();
            if (kind == e.kind && owner == e.owner && cyc == e.cyc &&
                (kind == EV_GRANT || cnt == e.cnt)) begin
                n_pass++;
                $display("event kind=%0d owner=%0d cyc=%0d cnt=%0d ok", kind, owner, cyc, cnt);
            end else begin
                $display("FAIL event: got kind=%0d owner=%0d cyc=%0d cnt=%0d, want kind=%0d owner=%0d cyc=%0d cnt=%0d",
                         kind, owner, cyc, cnt, e.kind, e.owner, e.cyc, e.cnt);
            end
        end
    endtask

    task automatic monitor();
        logic [1:0] prev;
        int seen_mr;
        prev = 2'b00;
        seen_mr = 0;
        forever begin
            @(negedge CLK);
            if (seen_mr != mr_count) begin
                seen_mr = mr_count;
                prev = 2'b00;
            end
            check("gnt_not_both", int'(GNT == 2'b11), 0);
            check("done_within_gnt", int'((DONE & ~GNT) != 2'b00 || DONE == 2'b11), 0);
            check("busy_matches_gnt", int'(BUSY), int'(GNT != 2'b00));
            while (q.size() > 0 && q[0].cyc < cyc) begin
                check("missed_event_cyc", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (prev == 2'b00 && GNT != 2'b00) take_event(EV_GRANT, int'(GNT[1]), 0);
            if (DONE != 2'b00) take_event(EV_DONE, int'(DONE[1]), int'(CNT));
            if (prev != 2'b00 && GNT == 2'b00) take_event(EV_REL, int'(prev[1]), int'(CNT));
            prev = GNT;
        end
    endtask

    // One transaction, called while the DUT sits in IDLE. The model works on
    // the timeline: grant at the next edge, load one edge later, then the
    // counter value (TOP - delay) climbs on TICK-high RUN edges; the first RUN
    // cycle that shows TOP is followed by the DONE cycle, then release.
    // tmode: 0 TICK always 1, 1 toggling, 2 random.
    // abort_val: -1 none, -2 drop in LOAD, else drop when the counter shows it.
    // mr_val: -1 none, else pulse MR when the counter shows it.
    task automatic job(input logic [1:0] req, input int d0, input int d1, input int tmode,
                       input int abort_val, input int mr_val, input bit rnd);
        int  w, d, val, runs;
        bit  ph, tk;
        REQ  = req;
        DLY0 = 4'(d0);
        DLY1 = 4'(d1);
        TICK = 1'($urandom_range(0, 1));
        w = (req == 2'b11) ? ptr : ((req == 2'b10) ? 1 : 0);
        d = (w == 1) ? d1 : d0;
        push(EV_GRANT, w, cyc + 1, 0);
        step();
        if (rnd) begin
            DLY0 = 4'($urandom_range(0, 15));
            DLY1 = 4'($urandom_range(0, 15));
        end
        if (abort_val == -2) begin
            REQ[w] = 1'b0;
            push(EV_REL, w, cyc + 1, cnt_model);
            ptr = 1 - w;
            step();
            REQ = 2'b00;
            return;
        end
        step();
        val = TOP - d;
        cnt_model = val;
        runs = 0;
        ph = 1'b1;
        forever begin
            if (mr_val >= 0 && val == mr_val) begin
                do_mr();
                return;
            end
            if (abort_val >= 0 && val == abort_val) begin
                REQ[w] = 1'b0;
                push(EV_REL, w, cyc + 1, val);
                ptr = 1 - w;
                step();
                REQ = 2'b00;
                return;
            end
            if (val == TOP) begin
                TICK = 1'($urandom_range(0, 1));
                push(EV_DONE, w, cyc + 1, TOP);
                push(EV_REL, w, cyc + 2, TOP);
                step();
                if (rnd) REQ = 2'($urandom_range(0, 3));
                step();
                REQ = 2'b00;
                ptr = 1 - w;
                return;
            end
            if (tmode == 0) tk = 1'b1;
            else if (tmode == 1) tk = ph;
            else tk = (runs > 60) ? 1'b1 : 1'($urandom_range(0, 1));
            ph = ~ph;
            TICK = tk;
            if (rnd) REQ[1-w] = 1'($urandom_range(0, 1));
            if (tk) val++;
            cnt_model = val;
            runs++;
            step();
        end
    endtask

    initial begin
        int w, d, r, av, d0, d1;
        logic [1:0] rq;
        fork
            begin
                #2000000;
                $display("FAIL watchdog: time limit reached, got %0d checks, want completion", n_checks);
                $fatal(1, "watchdog");
            end
        join_none
        repeat (2) @(posedge CLK);
        #1;
        check("reset_gnt", int'(GNT), 0);
        check("reset_done", int'(DONE), 0);
        check("reset_busy", int'(BUSY), 0);
        check("reset_cnt", int'(CNT), 0);
        MR = 1'b1;
        fork
            monitor();
        join_none

        // Directed cases.
        job(2'b01, 3, 0, 0, -1, -1, 1'b0);
        idle(1);
        do_mr();
        job(2'b11, 2, 5, 0, -1, -1, 1'b0);
        job(2'b11, 2, 5, 0, -1, -1, 1'b0);
        job(2'b10, 0, 0, 0, -1, -1, 1'b0);
        idle(1);
        job(2'b01, 15, 0, 1, -1, -1, 1'b0);
        job(2'b01, 10, 0, 0, 9, -1, 1'b0);
        job(2'b11, 3, 4, 0, -1, -1, 1'b0);
        job(2'b01, 8, 0, 0, -1, 10, 1'b0);
        job(2'b11, 1, 1, 0, -1, -1, 1'b0);
        job(2'b10, 5, 6, 0, -2, -1, 1'b0);

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            rq = 2'($urandom_range(1, 3));
            d0 = $urandom_range(0, 15);
            d1 = $urandom_range(0, 15);
            w  = (rq == 2'b11) ? ptr : ((rq == 2'b10) ? 1 : 0);
            d  = (w == 1) ? d1 : d0;
            r  = $urandom_range(0, 9);
            av = -1;
            if (r == 0) av = -2;
            else if (r < 3 && d > 0) av = $urandom_range(TOP - d, TOP - 1);
            job(rq, d0, d1, $urandom_range(0, 2), av, -1, 1'b1);
            idle($urandom_range(0, 2));
        end

        idle(4);
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
